// File: rtl/descrambler_1_if.sv
// Byte receive-path bundle between the line side and the descrambler.
// master: the source of scrambled bytes (and observer of results).
// slave:  the descrambler itself.
interface descrambler_1_if;
  logic       in_valid;
  logic       sync;
  logic [7:0] data_in;
  logic       out_valid;
  logic [7:0] data_out;
  logic       locked;

  modport master (
    output in_valid,
    output sync,
    output data_in,
    input  out_valid,
    input  data_out,
    input  locked
  );

  modport slave (
    input  in_valid,
    input  sync,
    input  data_in,
    output out_valid,
    output data_out,
    output locked
  );
endinterface

// File: rtl/descrambler_1.sv
// Byte-wide additive descrambler, receive partner of scrambler_1.
// Each received byte is XORed with 8 keystream bits from a 7-bit Fibonacci
// LFSR (x^7+x^4+1). A frame-sync strobe reseeds the LFSR and a two-state
// lock FSM tracks frame alignment; output is only produced while locked.
module descrambler_1 #(
  parameter logic [6:0] SEED      = 7'h7F,
  parameter int         FRAME_LEN = 64,
  parameter int         CNT_W     = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  descrambler_1_if.slave  bus
);

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_LEN);

  // Runs the LFSR eight steps from 'seed'; returns {state after byte, key byte}.
  // key[k] is the bit applied to data bit k (bit 0 goes first on the line).
  function automatic logic [14:0] keystream_byte(input logic [6:0] seed);
    logic [6:0] s;
    logic [7:0] key;
    s   = seed;
    key = 8'h00;
    for (int k = 0; k < 8; k++) begin
      key[k] = s[6] ^ s[3];
      s      = {s[5:0], key[k]};
    end
    return {s, key};
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [6:0]       lfsr_r, lfsr_s;
  logic [6:0]       start_s;
  logic [7:0]       key_s;
  logic [6:0]       after_s;
  logic             emit_s;
  logic             out_valid_r;
  logic [7:0]       data_out_r;
  logic             locked_r;

  // Keystream for this cycle's byte; a sync restarts it from the seed.
  always_comb begin
    start_s          = bus.sync ? SEED : lfsr_r;
    {after_s, key_s} = keystream_byte(start_s);
    if (bus.in_valid) begin
      lfsr_s = after_s;
    end else if (bus.sync) begin
      lfsr_s = SEED;
    end else begin
      lfsr_s = lfsr_r;
    end
  end

  // Lock FSM next state, byte counter and output-enable decision.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    emit_s  = 1'b0;
    case (state_r)
      UNLOCKED: begin
        if (bus.in_valid && bus.sync) begin
          state_s = LOCKED;
          cnt_s   = CNT_ONE;
          emit_s  = 1'b1;
        end else begin
          state_s = UNLOCKED;
        end
      end
      LOCKED: begin
        if (bus.in_valid && bus.sync) begin
          cnt_s  = CNT_ONE;
          emit_s = 1'b1;
        end else if (bus.in_valid && (cnt_r == CNT_FRAME)) begin
          // Frame overran without a sync: alignment lost, byte dropped.
          state_s = UNLOCKED;
          cnt_s   = CNT_ZERO;
        end else if (bus.in_valid) begin
          cnt_s  = cnt_r + CNT_ONE;
          emit_s = 1'b1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = UNLOCKED;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and LFSR registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= UNLOCKED;
      cnt_r   <= CNT_ZERO;
      lfsr_r  <= SEED;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      lfsr_r  <= lfsr_s;
    end
  end

  // Registered outputs; data_out holds its last value when nothing is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      data_out_r  <= 8'h00;
      locked_r    <= 1'b0;
    end else begin
      out_valid_r <= emit_s;
      locked_r    <= (state_s == LOCKED);
      if (emit_s) begin
        data_out_r <= bus.data_in ^ key_s;
      end else begin
        data_out_r <= data_out_r;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.data_out  = data_out_r;
  assign bus.locked    = locked_r;

endmodule

// File: tb/tb_descrambler_1.sv
// Directed self-checking bench for descrambler_1: a behavioural model pushes
// the expected output of every driven cycle into a scoreboard queue, which is
// popped and compared one cycle later when the registered outputs appear.
module tb_descrambler_1;

  localparam logic [6:0] SEED = 7'h7F;

  logic clk;
  logic rst_n;
  descrambler_1_if bus ();

  descrambler_1 #(.SEED(SEED), .FRAME_LEN(64), .CNT_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t sbq[$];
  int compared   = 0;
  int mismatched = 0;

  // reference model state
  logic [6:0] m_lfsr;
  logic       m_lock;
  int         m_cnt;
  logic [7:0] m_dout;

  // independent scrambler used for the round-trip test
  logic [6:0] tx_lfsr;

  logic [7:0] src[64];
  logic [7:0] ref_out[8];
  int         ref_n;

  // bit-serial keystream generator: returns next 8 key bits, advances state
  function automatic logic [7:0] gen_key(inout logic [6:0] s);
    logic [7:0] k;
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb   = s[6] ^ s[3];
      k[i] = fb;
      s    = (s << 1) | {6'd0, fb};
    end
    return k;
  endfunction

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED;
    m_lock = 1'b0;
    m_cnt  = 0;
    m_dout = 8'h00;
    sbq.delete();
  endtask

  // One cycle: drive inputs, predict, clock, pop and compare.
  task automatic step(input logic iv, input logic sy, input logic [7:0] din);
    logic [7:0] key;
    logic       emit;
    exp_t       e;
    @(negedge clk);
    bus.in_valid = iv;
    bus.sync     = sy;
    bus.data_in  = din;
    if (sy) m_lfsr = SEED;
    key  = 8'h00;
    if (iv) key = gen_key(m_lfsr);
    emit = 1'b0;
    if (iv && sy) begin
      m_lock = 1'b1; m_cnt = 1; emit = 1'b1;
    end else if (iv && m_lock) begin
      if (m_cnt == 64) begin
        m_lock = 1'b0; m_cnt = 0;
      end else begin
        m_cnt++; emit = 1'b1;
      end
    end
    if (emit) m_dout = din ^ key;
    e.v = emit; e.d = m_dout; e.l = m_lock;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    cmp("out_valid", {7'd0, bus.out_valid}, {7'd0, e.v});
    cmp("locked",    {7'd0, bus.locked},    {7'd0, e.l});
    cmp("data_out",  bus.data_out, e.d);
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    cmp("rst_out_valid", {7'd0, bus.out_valid}, 8'h00);
    cmp("rst_data_out",  bus.data_out,          8'h00);
    cmp("rst_locked",    {7'd0, bus.locked},    8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.sync     = 1'b0;
    bus.data_in  = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    cmp("reset_locked", {7'd0, bus.locked}, 8'h00);
    cmp("reset_dout",   bus.data_out, 8'h00);
    rst_n = 1'b1;

    // 1: known keystream bytes
    step(1'b1, 1'b1, 8'h00);
    cmp("t1_byte0", bus.data_out, 8'h70);
    step(1'b1, 1'b0, 8'h00);
    cmp("t1_byte1", bus.data_out, 8'h4F);
    cmp("t1_locked", {7'd0, bus.locked}, 8'h01);

    // 2: bytes before any sync are swallowed
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i * 37 + 3));
    step(1'b1, 1'b1, 8'h70);
    cmp("t2_sync_byte", bus.data_out, 8'h00);

    // 3: round trip against an independent scrambler
    tx_lfsr = SEED;
    for (int i = 0; i < 64; i++) begin
      src[i] = 8'($urandom_range(0, 255));
      step(1'b1, (i == 0), src[i] ^ gen_key(tx_lfsr));
      cmp("t3_roundtrip", bus.data_out, src[i]);
    end

    // 4: gapless reference run, then 1-0-0-1 gapped run must match
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 0), 8'(8'hA5 + i));
      ref_out[i] = bus.data_out;
    end
    ref_n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 0), 8'(8'hA5 + i));
      cmp("t4_gap", bus.data_out, ref_out[ref_n]);
      ref_n++;
      if (i != 7) begin
        step(1'b0, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 8'h11);
      end
    end
    cmp("t4_held", bus.data_out, ref_out[7]);

    // 5: 64-byte frame, 65th without sync drops lock, next sync relocks
    for (int i = 0; i < 64; i++) step(1'b1, (i == 0), 8'(i));
    cmp("t5_64th_valid", {7'd0, bus.out_valid}, 8'h01);
    step(1'b1, 1'b0, 8'h55);
    cmp("t5_65th_valid",  {7'd0, bus.out_valid}, 8'h00);
    cmp("t5_65th_locked", {7'd0, bus.locked},    8'h00);
    step(1'b1, 1'b1, 8'h00);
    cmp("t5_relock", bus.data_out, 8'h70);

    // 6: mid-frame resync at byte 10, sync without data, then async reset
    for (int i = 0; i < 10; i++) step(1'b1, (i == 0), 8'(i + 100));
    step(1'b1, 1'b1, 8'h00);
    cmp("t6_resync", bus.data_out, 8'h70);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    cmp("t6_idle_sync", bus.data_out, 8'h70);
    do_reset();
    step(1'b1, 1'b0, 8'h00);
    cmp("t6_post_rst", {7'd0, bus.out_valid}, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    cmp("t6_restart", bus.data_out, 8'h70);
    step(1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
